// File: rtl/div_unit.sv
// Iterative 32-bit RV32M divider (DIV/DIVU/REM/REMU) holding its result on a writeback port until acknowledged.
// Optional macro DIV_UNIT_EARLY_OUT_EN: divide-by-zero and signed overflow skip the iteration phase.
module div_unit (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [1:0]  op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic [4:0]  rd,
  input  logic        flush,
  output logic        ready,
  output logic        busy,
  output logic        wb_valid,
  output logic [4:0]  wb_rd,
  output logic [31:0] wb_data,
  input  logic        wb_ack
);

  localparam int unsigned XLEN  = 32;
  localparam int unsigned REG_W = 5;
  localparam int unsigned CNT_W = 5;

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_PREP = 3'd1;
  localparam logic [2:0] S_CALC = 3'd2;
  localparam logic [2:0] S_FIX  = 3'd3;
  localparam logic [2:0] S_DONE = 3'd4;

  logic [2:0]       state_q, state_d;
  logic [1:0]       op_q, op_d;
  logic [XLEN-1:0]  a_q, a_d, b_q, b_d;
  logic [REG_W-1:0] rd_q, rd_d;
  logic [XLEN-1:0]  dvs_q, dvs_d, quo_q, quo_d, rem_q, rem_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             neg_q_q, neg_q_d, neg_r_q, neg_r_d;
  logic             wb_valid_d;
  logic [REG_W-1:0] wb_rd_d;
  logic [XLEN-1:0]  wb_data_d;

  logic             signed_op, is_rem, div0, ovf;
  logic [XLEN-1:0]  a_abs, b_abs, q_fix, r_fix, result;
  logic [XLEN:0]    trial;

  assign signed_op = ~op_q[0];
  assign is_rem    = op_q[1];
  assign div0      = (b_q == '0);
  assign ovf       = signed_op && (a_q == 32'h8000_0000) && (b_q == 32'hFFFF_FFFF);
  assign a_abs     = (signed_op && a_q[XLEN-1]) ? (~a_q + 32'd1) : a_q;
  assign b_abs     = (signed_op && b_q[XLEN-1]) ? (~b_q + 32'd1) : b_q;

  // 33-bit trial subtraction of the divisor from the shifted partial remainder
  assign trial = {rem_q, quo_q[XLEN-1]} - {1'b0, dvs_q};

  assign q_fix = neg_q_q ? (~quo_q + 32'd1) : quo_q;
  assign r_fix = neg_r_q ? (~rem_q + 32'd1) : rem_q;

  always_comb begin
    result = is_rem ? r_fix : q_fix;
    if (div0) begin
      result = is_rem ? a_q : 32'hFFFF_FFFF;
    end else if (ovf) begin
      result = is_rem ? 32'd0 : 32'h8000_0000;
    end
  end

  assign ready = (state_q == S_IDLE);
  assign busy  = ~ready;

  always_comb begin
    state_d    = state_q;
    op_d       = op_q;
    a_d        = a_q;
    b_d        = b_q;
    rd_d       = rd_q;
    dvs_d      = dvs_q;
    quo_d      = quo_q;
    rem_d      = rem_q;
    cnt_d      = cnt_q;
    neg_q_d    = neg_q_q;
    neg_r_d    = neg_r_q;
    wb_valid_d = wb_valid;
    wb_rd_d    = wb_rd;
    wb_data_d  = wb_data;

    if (flush) begin
      state_d    = S_IDLE;
      wb_valid_d = 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (start) begin
            op_d    = op;
            a_d     = a;
            b_d     = b;
            rd_d    = rd;
            state_d = S_PREP;
          end
        end
        S_PREP: begin
          dvs_d   = b_abs;
          quo_d   = a_abs;
          rem_d   = '0;
          cnt_d   = '0;
          neg_q_d = signed_op & (a_q[XLEN-1] ^ b_q[XLEN-1]);
          neg_r_d = signed_op & a_q[XLEN-1];
          state_d = S_CALC;
`ifdef DIV_UNIT_EARLY_OUT_EN
          if (div0 || ovf) begin
            state_d = S_FIX;
          end
`endif
        end
        S_CALC: begin
          if (!trial[XLEN]) begin
            rem_d = trial[XLEN-1:0];
            quo_d = {quo_q[XLEN-2:0], 1'b1};
          end else begin
            rem_d = {rem_q[XLEN-2:0], quo_q[XLEN-1]};
            quo_d = {quo_q[XLEN-2:0], 1'b0};
          end
          cnt_d = CNT_W'(cnt_q + 5'd1);
          if (cnt_q == CNT_W'(XLEN - 1)) begin
            state_d = S_FIX;
          end
        end
        S_FIX: begin
          wb_data_d  = result;
          wb_rd_d    = rd_q;
          wb_valid_d = 1'b1;
          state_d    = S_DONE;
        end
        S_DONE: begin
          if (wb_ack) begin
            wb_valid_d = 1'b0;
            state_d    = S_IDLE;
          end
        end
        default: begin
          state_d    = S_IDLE;
          wb_valid_d = 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      op_q     <= '0;
      a_q      <= '0;
      b_q      <= '0;
      rd_q     <= '0;
      dvs_q    <= '0;
      quo_q    <= '0;
      rem_q    <= '0;
      cnt_q    <= '0;
      neg_q_q  <= 1'b0;
      neg_r_q  <= 1'b0;
      wb_valid <= 1'b0;
      wb_rd    <= '0;
      wb_data  <= '0;
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      a_q      <= a_d;
      b_q      <= b_d;
      rd_q     <= rd_d;
      dvs_q    <= dvs_d;
      quo_q    <= quo_d;
      rem_q    <= rem_d;
      cnt_q    <= cnt_d;
      neg_q_q  <= neg_q_d;
      neg_r_q  <= neg_r_d;
      wb_valid <= wb_valid_d;
      wb_rd    <= wb_rd_d;
      wb_data  <= wb_data_d;
    end
  end

endmodule

// File: tb/tb_div_unit.sv
// Directed bench for div_unit: results, latency, writeback hold, flush and async reset.
module tb_div_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [1:0]  op;
  logic [31:0] a, b;
  logic [4:0]  rd;
  logic        flush;
  logic        ready, busy, wb_valid;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;
  logic        wb_ack;

  int checks = 0;
  int errors = 0;

`ifdef DIV_UNIT_EARLY_OUT_EN
  localparam int SPECIAL_LAT = 2;
`else
  localparam int SPECIAL_LAT = 34;
`endif

  localparam logic [1:0] OP_DIV = 2'b00, OP_DIVU = 2'b01, OP_REM = 2'b10, OP_REMU = 2'b11;

  div_unit dut (
    .clk(clk), .rst_n(rst_n), .start(start), .op(op), .a(a), .b(b), .rd(rd),
    .flush(flush), .ready(ready), .busy(busy), .wb_valid(wb_valid),
    .wb_rd(wb_rd), .wb_data(wb_data), .wb_ack(wb_ack)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Presents one request at a negedge; returns at the negedge following the accepting edge.
  task automatic start_op(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y,
                          input logic [4:0] r);
    @(negedge clk);
    start = 1'b1; op = o; a = x; b = y; rd = r;
    @(negedge clk);
    start = 1'b0; op = 2'($urandom); a = $urandom; b = $urandom; rd = 5'($urandom);
  endtask

  task automatic wait_valid(input string tag, input int lat);
    int n = 0;
    while (!wb_valid && n < 80) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_lat"}, 32'(n), 32'(lat));
  endtask

  task automatic ack_result(input string tag);
    wb_ack = 1'b1;
    @(negedge clk);
    wb_ack = 1'b0;
    check({tag, "_ready"}, 32'(ready), 32'd1);
    check({tag, "_vdrop"}, 32'(wb_valid), 32'd0);
  endtask

  task automatic run_op(input string tag, input logic [1:0] o, input logic [31:0] x,
                        input logic [31:0] y, input logic [4:0] r, input logic [31:0] exp,
                        input int lat);
    start_op(o, x, y, r);
    wait_valid(tag, lat);
    check({tag, "_data"}, wb_data, exp);
    check({tag, "_rd"}, 32'(wb_rd), 32'(r));
    ack_result(tag);
  endtask

  initial begin
    bit seen;
    rst_n = 1'b0; start = 1'b0; op = '0; a = '0; b = '0; rd = '0; flush = 1'b0; wb_ack = 1'b0;
    #2;
    check("rst_ready", 32'(ready), 32'd1);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_valid", 32'(wb_valid), 32'd0);
    check("rst_rd", 32'(wb_rd), 32'd0);
    check("rst_data", wb_data, 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    run_op("divu_100_7", OP_DIVU, 32'd100, 32'd7, 5'd5, 32'd14, 34);
    run_op("remu_100_7", OP_REMU, 32'd100, 32'd7, 5'd5, 32'd2, 34);
    run_op("div_m7_2", OP_DIV, 32'hFFFF_FFF9, 32'd2, 5'd9, 32'hFFFF_FFFD, 34);
    run_op("rem_m7_2", OP_REM, 32'hFFFF_FFF9, 32'd2, 5'd9, 32'hFFFF_FFFF, 34);
    run_op("div_by0", OP_DIV, 32'd1234, 32'd0, 5'd1, 32'hFFFF_FFFF, SPECIAL_LAT);
    run_op("remu_by0", OP_REMU, 32'd1234, 32'd0, 5'd2, 32'd1234, SPECIAL_LAT);
    run_op("div_ovf", OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 5'd3, 32'h8000_0000, SPECIAL_LAT);
    run_op("rem_ovf", OP_REM, 32'h8000_0000, 32'hFFFF_FFFF, 5'd4, 32'd0, SPECIAL_LAT);
    run_op("divu_rd0", OP_DIVU, 32'd7, 32'd7, 5'd0, 32'd1, 34);

    // Result held while the arbiter withholds wb_ack; starts in the meantime are dropped.
    start_op(OP_DIVU, 32'd50, 32'd5, 5'd3);
    wait_valid("hold", 34);
    for (int i = 0; i < 5; i++) begin
      check("hold_valid", 32'(wb_valid), 32'd1);
      check("hold_data", wb_data, 32'd10);
      check("hold_rd", 32'(wb_rd), 32'd3);
      check("hold_ready", 32'(ready), 32'd0);
      start = (i % 2 == 0); op = OP_DIVU; a = 32'd1000; b = 32'd10; rd = 5'd8;
      @(negedge clk);
    end
    start = 1'b0;
    check("hold_end_data", wb_data, 32'd10);
    ack_result("hold");
    run_op("after_hold", OP_REMU, 32'd50, 32'd6, 5'd6, 32'd2, 34);

    // Flush sampled at the edge performing CALC iteration 10.
    start_op(OP_DIVU, 32'h0000_FFFF, 32'd3, 5'd12);
    repeat (11) @(negedge clk);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    check("flush_ready", 32'(ready), 32'd1);
    check("flush_busy", 32'(busy), 32'd0);
    check("flush_valid", 32'(wb_valid), 32'd0);
    seen = 1'b0;
    repeat (40) begin
      @(negedge clk);
      if (wb_valid) seen = 1'b1;
    end
    check("flush_never_valid", 32'(seen), 32'd0);

    // Asynchronous reset mid-CALC.
    start_op(OP_DIVU, 32'h0000_1000, 32'h10, 5'd14);
    repeat (8) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("arst_ready", 32'(ready), 32'd1);
    check("arst_busy", 32'(busy), 32'd0);
    check("arst_valid", 32'(wb_valid), 32'd0);
    check("arst_rd", 32'(wb_rd), 32'd0);
    check("arst_data", wb_data, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    run_op("divu_9_3", OP_DIVU, 32'd9, 32'd3, 5'd7, 32'd3, 34);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
